// File: rtl/mold_feed_arb.sv
// Packet-level round-robin arbiter: shares one MoldUDP64 parser input between
// two UDP AXI-stream feeds. Grants whole packets, truncates oversize packets
// (tlast+tuser forced) and drains their remainder.
module mold_feed_arb #(
  parameter int unsigned AXI_DATA_W   = 64,
  parameter int unsigned AXI_KEEP_W   = AXI_DATA_W / 8,
  parameter int unsigned PKT_MAX_BEAT = 192,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_axis_tvalid_i,
  input  logic [AXI_KEEP_W-1:0] a_axis_tkeep_i,
  input  logic [AXI_DATA_W-1:0] a_axis_tdata_i,
  input  logic                  a_axis_tlast_i,
  input  logic                  a_axis_tuser_i,
  output logic                  a_axis_tready_o,
  input  logic                  b_axis_tvalid_i,
  input  logic [AXI_KEEP_W-1:0] b_axis_tkeep_i,
  input  logic [AXI_DATA_W-1:0] b_axis_tdata_i,
  input  logic                  b_axis_tlast_i,
  input  logic                  b_axis_tuser_i,
  output logic                  b_axis_tready_o,
  output logic                  udp_axis_tvalid_o,
  output logic [AXI_KEEP_W-1:0] udp_axis_tkeep_o,
  output logic [AXI_DATA_W-1:0] udp_axis_tdata_o,
  output logic                  udp_axis_tlast_o,
  output logic                  udp_axis_tuser_o,
  input  logic                  udp_axis_tready_i,
  output logic                  grant_b_o,
  output logic                  trunc_v_o,
  output logic [CNT_W-1:0]      trunc_cnt_o
);

  // beat_cnt only needs to reach PKT_MAX_BEAT-1; the forced beat leaves FWD.
  localparam int unsigned BeatW = (PKT_MAX_BEAT > 2) ? $clog2(PKT_MAX_BEAT) : 1;
  localparam logic [BeatW-1:0] LastBeatIdx = BeatW'(PKT_MAX_BEAT - 1);

  typedef enum logic [1:0] {StIdle, StFwd, StDrain} state_e;

  state_e           state_q;
  logic             rr_pref_q;  // 0 = A preferred, 1 = B preferred
  logic [BeatW-1:0] beat_cnt_q;

  logic                  sel_b;
  logic                  sel_valid;
  logic [AXI_KEEP_W-1:0] sel_keep;
  logic [AXI_DATA_W-1:0] sel_data;
  logic                  sel_last;
  logic                  sel_user;
  logic                  sel_ready;
  logic                  force_trunc;
  logic                  accept;

  // Feed selection and zero-latency datapath mux.
  always_comb begin
    if (state_q == StIdle) begin
      sel_b = b_axis_tvalid_i & (~a_axis_tvalid_i | rr_pref_q);
    end else begin
      sel_b = grant_b_o;
    end
    sel_valid = sel_b ? b_axis_tvalid_i : a_axis_tvalid_i;
    sel_keep  = sel_b ? b_axis_tkeep_i  : a_axis_tkeep_i;
    sel_data  = sel_b ? b_axis_tdata_i  : a_axis_tdata_i;
    sel_last  = sel_b ? b_axis_tlast_i  : a_axis_tlast_i;
    sel_user  = sel_b ? b_axis_tuser_i  : a_axis_tuser_i;

    force_trunc = (beat_cnt_q == LastBeatIdx) & ~sel_last;

    udp_axis_tvalid_o = ~reset & (state_q != StDrain) & sel_valid;
    udp_axis_tkeep_o  = sel_keep;
    udp_axis_tdata_o  = sel_data;
    udp_axis_tlast_o  = sel_last | force_trunc;
    udp_axis_tuser_o  = sel_user | force_trunc;

    // While draining, the granted feed is consumed regardless of the parser.
    if (reset) begin
      sel_ready = 1'b0;
    end else if (state_q == StDrain) begin
      sel_ready = 1'b1;
    end else begin
      sel_ready = udp_axis_tready_i;
    end
    a_axis_tready_o = ~sel_b & sel_ready;
    b_axis_tready_o = sel_b & sel_ready;

    accept = udp_axis_tvalid_o & udp_axis_tready_i;
  end

  // Control FSM with registered grant, truncation pulse and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_b_o   <= 1'b0;
      rr_pref_q   <= 1'b0;
      beat_cnt_q  <= '0;
      trunc_v_o   <= 1'b0;
      trunc_cnt_o <= '0;
    end else begin
      trunc_v_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            grant_b_o <= sel_b;
            if (sel_last) begin
              rr_pref_q  <= ~sel_b;
              beat_cnt_q <= '0;
            end else begin
              state_q    <= StFwd;
              beat_cnt_q <= BeatW'(1);
            end
          end
        end
        StFwd: begin
          if (accept) begin
            if (sel_last) begin
              state_q    <= StIdle;
              rr_pref_q  <= ~grant_b_o;
              beat_cnt_q <= '0;
            end else if (force_trunc) begin
              state_q   <= StDrain;
              trunc_v_o <= 1'b1;
              if (trunc_cnt_o != '1) begin
                trunc_cnt_o <= trunc_cnt_o + 1'b1;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (sel_valid && sel_last) begin
            state_q    <= StIdle;
            rr_pref_q  <= ~grant_b_o;
            beat_cnt_q <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mold_feed_arb.sv
// Directed self-checking bench for mold_feed_arb with PKT_MAX_BEAT=4.
module tb_mold_feed_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_tvalid, a_tlast, a_tuser, a_tready;
  logic [7:0]  a_tkeep;
  logic [63:0] a_tdata;
  logic        b_tvalid, b_tlast, b_tuser, b_tready;
  logic [7:0]  b_tkeep;
  logic [63:0] b_tdata;
  logic        u_tvalid, u_tlast, u_tuser, u_tready;
  logic [7:0]  u_tkeep;
  logic [63:0] u_tdata;
  logic        grant_b, trunc_v;
  logic [15:0] trunc_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  mold_feed_arb #(
    .AXI_DATA_W  (64),
    .AXI_KEEP_W  (8),
    .PKT_MAX_BEAT(4),
    .CNT_W       (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .a_axis_tvalid_i  (a_tvalid),
    .a_axis_tkeep_i   (a_tkeep),
    .a_axis_tdata_i   (a_tdata),
    .a_axis_tlast_i   (a_tlast),
    .a_axis_tuser_i   (a_tuser),
    .a_axis_tready_o  (a_tready),
    .b_axis_tvalid_i  (b_tvalid),
    .b_axis_tkeep_i   (b_tkeep),
    .b_axis_tdata_i   (b_tdata),
    .b_axis_tlast_i   (b_tlast),
    .b_axis_tuser_i   (b_tuser),
    .b_axis_tready_o  (b_tready),
    .udp_axis_tvalid_o(u_tvalid),
    .udp_axis_tkeep_o (u_tkeep),
    .udp_axis_tdata_o (u_tdata),
    .udp_axis_tlast_o (u_tlast),
    .udp_axis_tuser_o (u_tuser),
    .udp_axis_tready_i(u_tready),
    .grant_b_o        (grant_b),
    .trunc_v_o        (trunc_v),
    .trunc_cnt_o      (trunc_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [63:0] d, input logic [7:0] k,
                       input logic l, input logic u);
    a_tvalid = v; a_tdata = d; a_tkeep = k; a_tlast = l; a_tuser = u;
  endtask

  task automatic set_b(input logic v, input logic [63:0] d, input logic [7:0] k,
                       input logic l, input logic u);
    b_tvalid = v; b_tdata = d; b_tkeep = k; b_tlast = l; b_tuser = u;
  endtask

  logic [63:0] exp2 [8];
  bit          t4_vld  [6];
  bit          t4_last [6];
  bit          t4_user [6];
  bit          t4_tv   [6];

  initial begin
    int a_pkt, a_beat, b_pkt, b_beat;
    bit a_adv, b_adv, exp_b;

    exp2 = '{64'hA000, 64'hA001, 64'hB000, 64'hB001,
             64'hA010, 64'hA011, 64'hB010, 64'hB011};
    t4_vld  = '{1, 1, 1, 1, 0, 0};
    t4_last = '{0, 0, 0, 1, 0, 0};
    t4_user = '{0, 1, 0, 1, 0, 0};
    t4_tv   = '{0, 0, 0, 0, 1, 0};

    // Reset: outputs quiet even with a valid feed.
    reset = 1'b1;
    u_tready = 1'b1;
    set_a(0, '0, '0, 0, 0);
    set_b(0, '0, '0, 0, 0);
    tick();
    tick();
    set_a(1, 64'h1111, 8'hFF, 0, 0);
    @(negedge clk);
    check("rst_tvalid", u_tvalid, 0);
    check("rst_a_rdy", a_tready, 0);
    check("rst_b_rdy", b_tready, 0);
    tick();
    reset = 1'b0;
    set_a(0, '0, '0, 0, 0);
    @(negedge clk);
    check("rst_grant", grant_b, 0);
    check("rst_trunc_v", trunc_v, 0);
    check("rst_trunc_cnt", trunc_cnt, 0);
    tick();

    // Test 1: A-only 3-beat packet.
    for (int k = 1; k <= 3; k++) begin
      set_a(1, 64'hAA00 + 64'(k), (k == 3) ? 8'h0F : 8'hFF, k == 3, 0);
      @(negedge clk);
      check("t1_tvalid", u_tvalid, 1);
      check("t1_data", u_tdata, 64'hAA00 + 64'(k));
      check("t1_keep", u_tkeep, (k == 3) ? 8'h0F : 8'hFF);
      check("t1_last", u_tlast, (k == 3) ? 1 : 0);
      check("t1_user", u_tuser, 0);
      check("t1_a_rdy", a_tready, 1);
      check("t1_b_rdy", b_tready, 0);
      tick();
      check("t1_grant", grant_b, 0);
    end
    set_a(0, '0, '0, 0, 0);
    // Back in IDLE: a lone B beat is picked up immediately.
    set_b(1, 64'hBB00, 8'hFF, 1, 0);
    @(negedge clk);
    check("t1_idle_data", u_tdata, 64'hBB00);
    check("t1_idle_b_rdy", b_tready, 1);
    tick();
    check("t1_idle_grant", grant_b, 1);
    set_b(0, '0, '0, 0, 0);

    // Test 2: continuous contention with 2-beat packets; strict alternation.
    a_pkt = 0; a_beat = 0; b_pkt = 0; b_beat = 0;
    for (int i = 0; i < 8; i++) begin
      set_a(1, 64'hA000 + 64'(a_pkt * 16 + a_beat), 8'hFF, a_beat == 1, 0);
      set_b(1, 64'hB000 + 64'(b_pkt * 16 + b_beat), 8'hFF, b_beat == 1, 0);
      exp_b = ((i / 2) % 2) == 1;
      @(negedge clk);
      check("t2_data", u_tdata, exp2[i]);
      check("t2_last", u_tlast, (i % 2) == 1);
      check("t2_a_rdy", a_tready, !exp_b);
      check("t2_b_rdy", b_tready, exp_b);
      if ((i % 2) == 1) check("t2_grant", grant_b, exp_b);
      a_adv = a_tready;
      b_adv = b_tready;
      tick();
      if (a_adv) begin
        if (a_beat == 1) begin a_beat = 0; a_pkt++; end else a_beat++;
      end
      if (b_adv) begin
        if (b_beat == 1) begin b_beat = 0; b_pkt++; end else b_beat++;
      end
    end
    set_a(0, '0, '0, 0, 0);
    set_b(0, '0, '0, 0, 0);

    // Test 3: valid drop and backpressure mid-packet, B waiting.
    set_a(1, 64'hA100, 8'hFF, 0, 0);
    set_b(1, 64'hB100, 8'hFF, 1, 0);
    @(negedge clk);
    check("t3_b1_data", u_tdata, 64'hA100);
    check("t3_b1_a_rdy", a_tready, 1);
    tick();
    set_a(0, '0, '0, 0, 0);
    @(negedge clk);
    check("t3_drop_tvalid", u_tvalid, 0);
    check("t3_drop_b_rdy", b_tready, 0);
    tick();
    set_a(1, 64'hA101, 8'h0F, 1, 0);
    u_tready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t3_bp_tvalid", u_tvalid, 1);
      check("t3_bp_data", u_tdata, 64'hA101);
      check("t3_bp_a_rdy", a_tready, 0);
      check("t3_bp_b_rdy", b_tready, 0);
      tick();
    end
    u_tready = 1'b1;
    @(negedge clk);
    check("t3_end_data", u_tdata, 64'hA101);
    check("t3_end_last", u_tlast, 1);
    check("t3_end_keep", u_tkeep, 8'h0F);
    check("t3_end_a_rdy", a_tready, 1);
    tick();
    set_a(0, '0, '0, 0, 0);
    @(negedge clk);
    check("t3_b_data", u_tdata, 64'hB100);
    check("t3_b_rdy", b_tready, 1);
    tick();
    set_b(0, '0, '0, 0, 0);

    // Test 4: 6-beat A packet truncated at beat 4, B queued behind it.
    set_b(1, 64'hB200, 8'hFF, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      set_a(1, 64'hA200 + 64'(k), 8'hFF, k == 6, k == 2);
      @(negedge clk);
      check("t4_tvalid", u_tvalid, t4_vld[k-1]);
      if (t4_vld[k-1]) begin
        check("t4_data", u_tdata, 64'hA200 + 64'(k));
        check("t4_last", u_tlast, t4_last[k-1]);
        check("t4_user", u_tuser, t4_user[k-1]);
      end
      check("t4_a_rdy", a_tready, 1);
      check("t4_b_rdy", b_tready, 0);
      check("t4_trunc_v", trunc_v, t4_tv[k-1]);
      if (k == 5) check("t4_trunc_cnt", trunc_cnt, 1);
      tick();
    end
    set_a(1, 64'hA300, 8'hFF, 1, 0);
    @(negedge clk);
    check("t4_next_data", u_tdata, 64'hB200);
    check("t4_next_b_rdy", b_tready, 1);
    check("t4_next_a_rdy", a_tready, 0);
    tick();
    set_b(0, '0, '0, 0, 0);
    @(negedge clk);
    check("t4_a300_data", u_tdata, 64'hA300);
    tick();
    set_a(0, '0, '0, 0, 0);

    // Test 5: exactly PKT_MAX_BEAT beats, no truncation.
    for (int k = 1; k <= 4; k++) begin
      set_a(1, 64'hA400 + 64'(k), 8'hFF, k == 4, 0);
      @(negedge clk);
      check("t5_data", u_tdata, 64'hA400 + 64'(k));
      check("t5_last", u_tlast, k == 4);
      check("t5_user", u_tuser, 0);
      check("t5_trunc_v", trunc_v, 0);
      tick();
    end
    set_a(0, '0, '0, 0, 0);
    @(negedge clk);
    check("t5_trunc_v_after", trunc_v, 0);
    check("t5_trunc_cnt", trunc_cnt, 1);
    tick();

    // Test 6: reset during beat 2 of a B packet.
    set_b(1, 64'hB500, 8'hFF, 0, 0);
    @(negedge clk);
    check("t6_b1_data", u_tdata, 64'hB500);
    check("t6_b1_b_rdy", b_tready, 1);
    tick();
    set_b(1, 64'hB501, 8'hFF, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_tvalid", u_tvalid, 0);
    check("t6_rst_a_rdy", a_tready, 0);
    check("t6_rst_b_rdy", b_tready, 0);
    tick();
    reset = 1'b0;
    set_a(1, 64'hA600, 8'hFF, 1, 0);
    set_b(1, 64'hB600, 8'hFF, 1, 0);
    @(negedge clk);
    check("t6_post_data", u_tdata, 64'hA600);
    check("t6_post_a_rdy", a_tready, 1);
    check("t6_post_b_rdy", b_tready, 0);
    check("t6_post_grant", grant_b, 0);
    check("t6_post_trunc_cnt", trunc_cnt, 0);
    tick();
    @(negedge clk);
    check("t6_next_data", u_tdata, 64'hB600);
    check("t6_next_b_rdy", b_tready, 1);
    tick();
    set_a(0, '0, '0, 0, 0);
    set_b(0, '0, '0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
